// File: rtl/adc_capture_hls_deadlock_param_monitor.sv
// -----------------------------------------------------------------------------
// adc_capture_hls_deadlock_param_monitor
//
// Purpose:
//   Watches an HLS-generated ADC capture pipeline for a deadlock. The pipeline
//   is suspected to be deadlocked ("candidate") when some sub-instance reports
//   blocked, some AXI-stream reports a full/empty stall, and not every
//   sub-instance is idle. Once the candidate has held for THRESHOLD
//   consecutive cycles the monitor asserts block. A sticky copy and the
//   lowest stalled stream index are kept for software until cleared.
//
// Parameters:
//   N_AXIS    number of AXI-stream stall flags (1..32)
//   N_INST    number of monitored sub-instances (1..32)
//   THRESHOLD consecutive candidate cycles before block asserts (1..65535)
//   IDX_W     width of first_axis_idx (>= clog2(N_AXIS))
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   axis_block_sigs in   [N_AXIS] per-stream stall flags
//   inst_idle_sigs  in   [N_INST] per-instance idle flags
//   inst_block_sigs in   [N_INST] per-instance blocked flags
//   clear           in   pulse clearing block_sticky / first_axis_idx
//   block           out  live deadlock indication (registered)
//   block_sticky    out  latched deadlock indication
//   first_axis_idx  out  [IDX_W] lowest stalled stream at BLOCKED entry
//   block_count     out  [16] number of BLOCKED entries
//
// Build option:
//   DEADLOCK_MON_EVENT_CNT_EN  when defined, block_count is a saturating count
//                              of BLOCKED entries; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module adc_capture_hls_deadlock_param_monitor #(
  parameter int N_AXIS    = 2,
  parameter int N_INST    = 3,
  parameter int THRESHOLD = 16,
  parameter int IDX_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              block_sticky,
  output logic [IDX_W-1:0]  first_axis_idx,
  output logic [15:0]       block_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  localparam logic [15:0] THR_M1 = 16'(THRESHOLD - 1);

  state_t             state_q, state_d;
  logic [15:0]        run_q, run_d;
  logic               block_q;
  logic               sticky_q, sticky_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               candidate;
  logic               enter_blk;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_AXIS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign candidate = (|inst_block_sigs) & (|axis_block_sigs) & ~(&inst_idle_sigs);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      IDLE: begin
        if (candidate) begin
          // A threshold of one means the very first candidate cycle qualifies.
          state_d = (THRESHOLD == 1) ? BLOCKED : ARMED;
          run_d   = 16'd1;
        end
      end
      ARMED: begin
        if (!candidate) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (run_q == THR_M1) begin
          state_d = BLOCKED;
          run_d   = run_q + 16'd1;
        end else begin
          run_d   = run_q + 16'd1;
        end
      end
      BLOCKED: begin
        // Count is frozen here so it can never wrap during a long deadlock.
        if (!candidate) begin
          state_d = IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  assign enter_blk = (state_q != BLOCKED) && (state_d == BLOCKED);

  always_comb begin
    sticky_d = sticky_q;
    idx_d    = idx_q;
    // A new BLOCKED entry takes priority over a coincident clear.
    if (enter_blk) begin
      sticky_d = 1'b1;
      idx_d    = lowest_idx(axis_block_sigs);
    end else if (clear) begin
      sticky_d = 1'b0;
      idx_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      run_q    <= '0;
      block_q  <= 1'b0;
      sticky_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      block_q  <= (state_d == BLOCKED);
      sticky_q <= sticky_d;
      idx_q    <= idx_d;
    end
  end

  assign block          = block_q;
  assign block_sticky   = sticky_q;
  assign first_axis_idx = idx_q;

`ifdef DEADLOCK_MON_EVENT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enter_blk && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign block_count = cnt_q;
`else
  assign block_count = '0;
`endif

endmodule

// File: tb/tb_adc_capture_hls_deadlock_param_monitor.sv
module tb_adc_capture_hls_deadlock_param_monitor;

  localparam int THR = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  axis_block_sigs;
  logic [2:0]  inst_idle_sigs;
  logic [2:0]  inst_block_sigs;
  logic        clear;
  logic        block, block_sticky;
  logic [4:0]  first_axis_idx;
  logic [15:0] block_count;
  logic        block1, block_sticky1;
  logic [4:0]  first_axis_idx1;
  logic [15:0] block_count1;

  always #5 clock = ~clock;

  adc_capture_hls_deadlock_param_monitor #(
    .N_AXIS(2), .N_INST(3), .THRESHOLD(THR), .IDX_W(5)
  ) dut (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .clear(clear), .block(block), .block_sticky(block_sticky),
    .first_axis_idx(first_axis_idx), .block_count(block_count)
  );

  adc_capture_hls_deadlock_param_monitor #(
    .N_AXIS(2), .N_INST(3), .THRESHOLD(1), .IDX_W(5)
  ) dut1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .clear(clear), .block(block1), .block_sticky(block_sticky1),
    .first_axis_idx(first_axis_idx1), .block_count(block_count1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural reference: length of the current run of candidate cycles.
  int       m_run  = 0;
  int       m_run1 = 0;
  logic     m_st   = 1'b0;
  int       m_idx  = 0;
  int       m_cnt  = 0;
  int       m_cnt1 = 0;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [1:0] ab;
    logic [2:0] ib;
    logic [2:0] idl;
    logic       eb;
    logic       es;
    logic [4:0] ei;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic int exp_count(input int entries);
`ifdef DEADLOCK_MON_EVENT_CNT_EN
    return entries;
`else
    return 0 * entries;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic clr, input logic [1:0] ab,
                     input logic [2:0] ib, input logic [2:0] idl,
                     input logic eb, input logic es, input logic [4:0] ei,
                     input int ec);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ab = ab; v.ib = ib; v.idl = idl;
    v.eb = eb; v.es = es; v.ei = ei; v.ec = ec;
    tbl.push_back(v);
  endtask

  // Apply one cycle of inputs, advance the reference model across the edge,
  // and return 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic clr, input logic [1:0] ab,
                     input logic [2:0] ib, input logic [2:0] idl);
    logic cand;
    int   old;
    reset = rst; clear = clr; axis_block_sigs = ab;
    inst_block_sigs = ib; inst_idle_sigs = idl;
    @(posedge clock);
    cand = (ib != 3'b000) && (ab != 2'b00) && (idl != 3'b111);
    if (rst) begin
      m_run = 0; m_run1 = 0; m_st = 1'b0; m_idx = 0; m_cnt = 0; m_cnt1 = 0;
    end else begin
      old    = m_run;
      m_run  = cand ? ((m_run < THR) ? m_run + 1 : m_run) : 0;
      if (cand && m_run1 == 0 && m_cnt1 < 65535) m_cnt1++;
      m_run1 = cand ? 1 : 0;
      if (cand && old < THR && m_run == THR) begin
        m_st  = 1'b1;
        m_idx = ab[0] ? 0 : 1;
        if (m_cnt < 65535) m_cnt++;
      end else if (clr) begin
        m_st  = 1'b0;
        m_idx = 0;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; axis_block_sigs = '0;
    inst_block_sigs = '0; inst_idle_sigs = '0;

    // rst clr ab    ib      idl     | blk st idx entries
    add(1, 0, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
    add(0, 0, 2'b01, 3'b001, 3'b000, 0, 0, 0, 0);
    add(0, 0, 2'b01, 3'b001, 3'b000, 0, 0, 0, 0);
    add(0, 0, 2'b01, 3'b001, 3'b000, 0, 0, 0, 0);
    add(0, 0, 2'b01, 3'b001, 3'b000, 1, 1, 0, 1);
    add(0, 0, 2'b00, 3'b001, 3'b000, 0, 1, 0, 1);
    add(0, 1, 2'b00, 3'b001, 3'b000, 0, 0, 0, 1);
    add(0, 0, 2'b11, 3'b100, 3'b010, 0, 0, 0, 1);
    add(0, 0, 2'b11, 3'b100, 3'b010, 0, 0, 0, 1);
    add(0, 0, 2'b11, 3'b100, 3'b010, 0, 0, 0, 1);
    add(0, 0, 2'b11, 3'b000, 3'b010, 0, 0, 0, 1);
    add(0, 0, 2'b10, 3'b010, 3'b011, 0, 0, 0, 1);
    add(0, 0, 2'b10, 3'b010, 3'b011, 0, 0, 0, 1);
    add(0, 0, 2'b10, 3'b010, 3'b011, 0, 0, 0, 1);
    add(0, 0, 2'b10, 3'b010, 3'b011, 1, 1, 1, 2);
    add(0, 0, 2'b11, 3'b010, 3'b011, 1, 1, 1, 2);
    add(0, 0, 2'b11, 3'b111, 3'b111, 0, 1, 1, 2);
    add(0, 0, 2'b11, 3'b111, 3'b111, 0, 1, 1, 2);
    add(0, 1, 2'b11, 3'b111, 3'b111, 0, 0, 0, 2);
    add(0, 0, 2'b01, 3'b001, 3'b000, 0, 0, 0, 2);
    add(0, 0, 2'b01, 3'b001, 3'b000, 0, 0, 0, 2);
    add(0, 0, 2'b01, 3'b001, 3'b000, 0, 0, 0, 2);
    add(0, 1, 2'b01, 3'b001, 3'b000, 1, 1, 0, 3);

    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].clr, tbl[k].ab, tbl[k].ib, tbl[k].idl);
      chk($sformatf("tbl%0d_block", k), int'(block), int'(tbl[k].eb));
      chk($sformatf("tbl%0d_sticky", k), int'(block_sticky), int'(tbl[k].es));
      chk($sformatf("tbl%0d_idx", k), int'(first_axis_idx), int'(tbl[k].ei));
      chk($sformatf("tbl%0d_count", k), int'(block_count), exp_count(tbl[k].ec));
    end

    // Reset while BLOCKED with the candidate still high clears everything.
    cyc(1, 0, 2'b01, 3'b001, 3'b000);
    chk("rst_blk_block", int'(block), 0);
    chk("rst_blk_sticky", int'(block_sticky), 0);
    chk("rst_blk_idx", int'(first_axis_idx), 0);
    chk("rst_blk_count", int'(block_count), 0);
    // Counting restarts from zero once reset is released.
    for (int i = 1; i <= THR; i++) begin
      cyc(0, 0, 2'b01, 3'b001, 3'b000);
      chk($sformatf("post_rst_block%0d", i), int'(block), (i == THR) ? 1 : 0);
    end
    chk("post_rst_count", int'(block_count), exp_count(1));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic       r, c;
      logic [1:0] ab;
      logic [2:0] ib, idl;
      r   = ($urandom_range(0, 99) == 0);
      c   = ($urandom_range(0, 9) == 0);
      ab  = 2'($urandom);
      ib  = 3'($urandom);
      idl = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0)};
      cyc(r, c, ab, ib, idl);
      chk("rnd_block", int'(block), (m_run >= THR) ? 1 : 0);
      chk("rnd_sticky", int'(block_sticky), int'(m_st));
      chk("rnd_idx", int'(first_axis_idx), m_idx);
      chk("rnd_count", int'(block_count), exp_count(m_cnt));
      chk("rnd_thr1_block", int'(block1), m_run1);
      chk("rnd_thr1_count", int'(block_count1), exp_count(m_cnt1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
